// File: rtl/baud_gen.sv
// Free-running mod-M counter producing a one-cycle UART sampling tick every M clocks.
// The tick is a combinational decode of the registered count, so it needs no extra state.
module baud_gen #(
  parameter int N = 12,
  parameter int M = 326
) (
  input  logic         clk,
  input  logic         reset,
  output logic [N-1:0] q,
  output logic         tick
);

  // M == 2**N is legal, so M-1 must still fit in N bits.
  localparam logic [N-1:0] LAST = N'(M - 1);

  generate
    if (M < 2 || M > (2 ** N)) begin : g_bad_modulus
      $error("baud_gen: modulus M=%0d out of range for N=%0d", M, N);
    end
  endgenerate

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;
  logic         at_last;

  assign at_last = (q_q == LAST);

  always_comb begin
    q_d = q_q + N'(1);
    if (at_last) begin
      q_d = '0;
    end
  end

  // Active-low reset wins over both counting and wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign tick = at_last;

endmodule

// File: tb/tb_baud_gen.sv
// Directed bench for baud_gen: default M=326 plus M=2 and M=4096 instances.
`timescale 1ns/1ps
module tb_baud_gen;

  logic        clk;
  logic        rst_main;
  logic        rst_m2;
  logic        rst_big;
  logic [11:0] q_main;
  logic        tick_main;
  logic [11:0] q_m2;
  logic        tick_m2;
  logic [11:0] q_big;
  logic        tick_big;

  int n_assert;
  int n_fail;

  baud_gen #(.N(12), .M(326)) u_main (
    .clk(clk), .reset(rst_main), .q(q_main), .tick(tick_main)
  );
  baud_gen #(.N(12), .M(2)) u_m2 (
    .clk(clk), .reset(rst_m2), .q(q_m2), .tick(tick_m2)
  );
  baud_gen #(.N(12), .M(4096)) u_big (
    .clk(clk), .reset(rst_big), .q(q_big), .tick(tick_big)
  );

  // 50 MHz clock
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int     cnt;
    int     rises;
    int     streak;
    longint last_rise;
    logic   prev_tick;
    logic   found;

    n_assert = 0;
    n_fail   = 0;
    rst_main = 1'b0;
    rst_m2   = 1'b0;
    rst_big  = 1'b0;

    // Reset: two edges, then ten more held.
    repeat (2) @(negedge clk);
    check("reset_q", q_main, 0);
    check("reset_tick", tick_main, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset_hold_q", q_main, 0);
      check("reset_hold_tick", tick_main, 0);
    end

    // Count-up from release, through the tick and the wrap.
    rst_main = 1'b1;
    for (int k = 1; k <= 324; k++) begin
      @(negedge clk);
      check("count_q", q_main, k);
      check("count_tick", tick_main, 0);
    end
    @(negedge clk);
    check("last_q", q_main, 325);
    check("last_tick", tick_main, 1);
    @(negedge clk);
    check("wrap_q", q_main, 0);
    check("wrap_tick", tick_main, 0);

    // Period over 1 ms: rising ticks 6520 ns apart, each 20 ns wide.
    rises     = 0;
    streak    = 0;
    last_rise = 0;
    prev_tick = tick_main;
    for (int c = 0; c < 50000; c++) begin
      @(negedge clk);
      if (q_main >= 12'd326) check("q_range", q_main, 0);
      if (tick_main && !prev_tick) begin
        if (rises > 0) check("tick_period_ns", longint'($time) - last_rise, 6520);
        last_rise = longint'($time);
        rises++;
      end
      if (tick_main) begin
        streak++;
      end else begin
        if (streak != 0) check("tick_width_cycles", streak, 1);
        streak = 0;
      end
      prev_tick = tick_main;
    end
    n_assert++;
    assert (rises >= 150) else begin
      n_fail++;
      $error("FAIL tick_count observed=%0d expected>=150", rises);
    end

    // Mid-count reset at q==200, then a full M-1 edges to the next tick.
    found = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(negedge clk);
      if (q_main == 12'd200) found = 1'b1;
    end
    check("find_q200", found, 1);
    rst_main = 1'b0;
    @(negedge clk);
    check("midreset_q", q_main, 0);
    check("midreset_tick", tick_main, 0);
    rst_main = 1'b1;
    cnt = 0;
    found = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(negedge clk);
      cnt++;
      if (tick_main) found = 1'b1;
    end
    check("post_reset_tick_edges", cnt, 325);

    // Reset while the tick is high.
    rst_main = 1'b0;
    @(negedge clk);
    check("reset_at_last_q", q_main, 0);
    check("reset_at_last_tick", tick_main, 0);
    rst_main = 1'b1;

    // M=2: tick alternates every cycle starting high after edge 0.
    rst_m2 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("m2_tick", tick_m2, (k % 2 == 0) ? 1 : 0);
      check("m2_q", q_m2, (k % 2 == 0) ? 1 : 0);
    end

    // M=4096: full-range count, tick at 4095, wrap to 0.
    check("big_reset_q", q_big, 0);
    rst_big = 1'b1;
    repeat (4094) @(negedge clk);
    check("big_q_4094", q_big, 4094);
    check("big_tick_4094", tick_big, 0);
    @(negedge clk);
    check("big_q_4095", q_big, 4095);
    check("big_tick_4095", tick_big, 1);
    @(negedge clk);
    check("big_wrap_q", q_big, 0);
    check("big_wrap_tick", tick_big, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
